elevator_car_ctrl: RTL

Parametrised elevator car controller. It accepts a target-floor request through a valid/ready handshake and moves the car one floor per `TRAVEL_CYCLES` in the correct direction, without wrap-around. On arrival it holds the door open for `DOOR_CYCLES` cycles. It drives the floor register, the direction code and an active-low one-hot floor indicator for the LED matrix rows, and sits between the request/button logic and the display driver.

---
 rtl/elevator_pkg.sv | 15 +
 rtl/floor_decoder.sv | 21 ++
 rtl/elevator_car_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller and its display helpers:
// direction codes and the car FSM state set.
package elevator_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;

    typedef enum logic [1:0] {
        CAR_IDLE = 2'b00,
        CAR_MOVE = 2'b01,
        CAR_DOOR = 2'b10
    } car_state_t;

endpackage

// File: rtl/floor_decoder.sv
// Binary floor index to active-low one-hot row select; bits beyond the
// current floor are held high. Also used by the LED matrix display driver.
module floor_decoder
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS = 7,
    localparam int FW         = $clog2(NUM_FLOORS)
) (
    input  logic [FW-1:0]         floor,
    output logic [NUM_FLOORS-1:0] floor_n
);

    // One row low for the matching floor, all others high
    always_comb begin
        floor_n = '1;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_n[i] = (floor != FW'(i));
        end
    end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: accepts one target floor at a time, travels one
// floor per TRAVEL_CYCLES, then holds the door open for DOOR_CYCLES.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS    = 7,
    parameter  int TRAVEL_CYCLES = 4,
    parameter  int DOOR_CYCLES   = 8,
    localparam int FW            = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FW-1:0]         req_floor,
    output logic                  req_ready,
    output logic [FW-1:0]         floor,
    output logic [1:0]            dir,
    output logic                  door_open,
    output logic                  arrive,
    output logic                  err,
    output logic [NUM_FLOORS-1:0] floor_n
);

    localparam int SW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [SW-1:0] STEP_LAST = SW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    localparam logic [1:0] ST_IDLE = CAR_IDLE;
    localparam logic [1:0] ST_MOVE = CAR_MOVE;
    localparam logic [1:0] ST_DOOR = CAR_DOOR;

    logic [1:0]    state_r;
    logic [FW-1:0] floor_r;
    logic [FW-1:0] target_r;
    logic [1:0]    dir_r;
    logic [SW-1:0] step_cnt_r;
    logic [DW-1:0] door_cnt_r;
    logic          door_open_r;
    logic          arrive_r;
    logic          err_r;

    logic [FW-1:0] next_floor_s;
    logic          req_oor_s;
    logic          accept_s;

    assign req_ready = (state_r == ST_IDLE);
    assign accept_s  = req_valid && req_ready;
    // Extra bit so a full 2^FW floor count still compares correctly
    assign req_oor_s = ({1'b0, req_floor} >= (FW+1)'(NUM_FLOORS));

    assign floor     = floor_r;
    assign dir       = dir_r;
    assign door_open = door_open_r;
    assign arrive    = arrive_r;
    assign err       = err_r;

    // Neighbouring floor in the travel direction, clamped at both ends
    always_comb begin
        next_floor_s = floor_r;
        if ((dir_r == DIR_UP) && (floor_r < TOP_FLOOR)) begin
            next_floor_s = floor_r + FW'(1);
        end else if ((dir_r == DIR_DOWN) && (floor_r != '0)) begin
            next_floor_s = floor_r - FW'(1);
        end else begin
            next_floor_s = floor_r;
        end
    end

    // Car FSM with travel/door timers and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            floor_r     <= '0;
            target_r    <= '0;
            dir_r       <= DIR_STOP;
            step_cnt_r  <= '0;
            door_cnt_r  <= '0;
            door_open_r <= 1'b0;
            arrive_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            arrive_r <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (req_oor_s) begin
                            err_r <= 1'b1;
                        end else if (req_floor == floor_r) begin
                            state_r     <= ST_DOOR;
                            arrive_r    <= 1'b1;
                            door_open_r <= 1'b1;
                            door_cnt_r  <= '0;
                        end else begin
                            state_r    <= ST_MOVE;
                            target_r   <= req_floor;
                            dir_r      <= (req_floor > floor_r) ? DIR_UP : DIR_DOWN;
                            step_cnt_r <= '0;
                        end
                    end
                end
                ST_MOVE: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_r <= '0;
                        floor_r    <= next_floor_s;
                        if (next_floor_s == target_r) begin
                            state_r     <= ST_DOOR;
                            dir_r       <= DIR_STOP;
                            arrive_r    <= 1'b1;
                            door_open_r <= 1'b1;
                            door_cnt_r  <= '0;
                        end
                    end else begin
                        step_cnt_r <= step_cnt_r + SW'(1);
                    end
                end
                ST_DOOR: begin
                    if (door_cnt_r == DOOR_LAST) begin
                        state_r     <= ST_IDLE;
                        door_open_r <= 1'b0;
                        door_cnt_r  <= '0;
                    end else begin
                        door_cnt_r <= door_cnt_r + DW'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    dir_r       <= DIR_STOP;
                    step_cnt_r  <= '0;
                    door_cnt_r  <= '0;
                    door_open_r <= 1'b0;
                end
            endcase
        end
    end

    floor_decoder #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_floor_decoder (
        .floor   (floor_r),
        .floor_n (floor_n)
    );

endmodule
